// File: rtl/alu_ctrl_seq.sv
// Registered multi-cycle ALU control decoder: accepts one decode request per
// handshake, then holds the control code until its class latency has elapsed.
module alu_ctrl_seq #(
  parameter int INT_LAT  = 1,
  parameter int FMUL_LAT = 3,
  parameter int FADD_LAT = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic             fp_operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_control,
  output logic             illegal,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAT_INT  = CNT_W'(INT_LAT);
  localparam logic [CNT_W-1:0] LAT_FMUL = CNT_W'(FMUL_LAT);
  localparam logic [CNT_W-1:0] LAT_FADD = CNT_W'(FADD_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_HOLD = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       ctrl_q;
  logic             illegal_q;

  logic [3:0]       dec_ctrl;
  logic             dec_ill;
  logic [CNT_W-1:0] dec_lat;
  logic             ready_c;
  logic             accept;

  // Pure decode of the presented request; only captured on accept.
  always_comb begin
    dec_ctrl = 4'b0000;
    dec_ill  = 1'b0;
    dec_lat  = LAT_INT;
    if (fp_operation) begin
      case (funct)
        6'b000000: begin dec_ctrl = 4'b1101; dec_lat = LAT_FADD; end
        6'b000001: begin dec_ctrl = 4'b0011; dec_lat = LAT_FADD; end
        6'b000010: begin dec_ctrl = 4'b1100; dec_lat = LAT_FMUL; end
        6'b000100: begin dec_ctrl = 4'b1110; dec_lat = LAT_FADD; end
        6'b000110: begin dec_ctrl = 4'b1111; dec_lat = LAT_FADD; end
        default:   dec_ill = 1'b1;
      endcase
    end else begin
      case (alu_op)
        2'b00: dec_ctrl = 4'b0010;
        2'b01: dec_ctrl = 4'b0110;
        2'b10: begin
          case (funct)
            6'b100000: dec_ctrl = 4'b0010;
            6'b100010: dec_ctrl = 4'b0110;
            6'b100100: dec_ctrl = 4'b0000;
            6'b100101: dec_ctrl = 4'b0001;
            6'b101010: dec_ctrl = 4'b0111;
            6'b000000: dec_ctrl = 4'b1000;
            6'b000010: dec_ctrl = 4'b1001;
            6'b100110: dec_ctrl = 4'b1010;
            6'b100111: dec_ctrl = 4'b1011;
            default:   dec_ill  = 1'b1;
          endcase
        end
        default: begin
          case (funct[5:3])
            3'b001:  dec_ctrl = 4'b0000;
            3'b010:  dec_ctrl = 4'b0001;
            3'b011:  dec_ctrl = 4'b1010;
            default: dec_ctrl = 4'b0010;
          endcase
        end
      endcase
    end
  end

  // HOLD accepts only when the current result is consumed in the same cycle.
  always_comb begin
    ready_c = 1'b0;
    case (state_q)
      S_IDLE:  ready_c = 1'b1;
      S_HOLD:  ready_c = out_ready;
      default: ready_c = 1'b0;
    endcase
    if (rst || flush) ready_c = 1'b0;
  end

  assign accept = in_valid && ready_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      cnt_d   = dec_lat - CNT_ONE;
      state_d = (dec_lat <= CNT_ONE) ? S_HOLD : S_EXEC;
    end else begin
      case (state_q)
        S_EXEC: begin
          if (cnt_q <= CNT_ONE) state_d = S_HOLD;
          else                  cnt_d   = cnt_q - CNT_ONE;
        end
        S_HOLD: begin
          if (out_ready) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ctrl_q    <= 4'b0000;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        ctrl_q    <= dec_ctrl;
        illegal_q <= dec_ill;
      end
    end
  end

  assign in_ready    = ready_c;
  assign out_valid   = (state_q == S_HOLD);
  assign busy        = (state_q != S_IDLE);
  assign alu_control = ctrl_q;
  assign illegal     = illegal_q;

endmodule
